// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard: forward-select codes,
// the load flag position inside ResultSrc and the stall-cause bundle.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_LONG = 2'b11;

  localparam int RESULT_SRC_LOAD_BIT = 0;

  // Wide enough for LONG_LAT-1 with LONG_LAT up to 15.
  localparam int LAT_CNT_W = 4;

  typedef struct packed {
    logic raw;
    logic load_use;
    logic scoreboard;
    logic waw;
    logic structural;
  } stall_cause_t;

endpackage

// File: rtl/hazard_scoreboard_long_op_tracker.sv
// Tracks the single in-flight long-latency op: busy flag, remaining-cycle
// count, destination index and the one-cycle writeback pulse.
module long_op_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [REG_AW-1:0] rd,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] long_rd
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LONG_LAT - 1);

  logic                 busy_reg, busy_next;
  logic [LAT_CNT_W-1:0] cnt_reg, cnt_next;
  logic [REG_AW-1:0]    rd_reg, rd_next;

  assign busy    = busy_reg;
  assign done    = busy_reg && (cnt_reg == '0);
  assign long_rd = rd_reg;

  // An issue attempt while busy is ignored; a zero destination never starts an op.
  always_comb begin
    busy_next = busy_reg;
    cnt_next  = cnt_reg;
    rd_next   = rd_reg;
    if (busy_reg) begin
      if (cnt_reg != '0) begin
        cnt_next = cnt_reg - 1'b1;
      end else begin
        busy_next = 1'b0;
      end
    end else if (issue && (rd != '0)) begin
      busy_next = 1'b1;
      rd_next   = rd;
      cnt_next  = CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      rd_reg   <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
      rd_reg   <= rd_next;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage forwarding, D-stage stall/flush generation
// around one long-latency unit, plus stall and flush performance counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 32,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              LongOpD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              LongOpE,
  input  logic [1:0]        ResultSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              LongDone,
  output logic [REG_AW-1:0] LongRd,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCount
);

  logic busy;

  long_op_tracker #(
    .REG_AW  (REG_AW),
    .LONG_LAT(LONG_LAT)
  ) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .issue  (LongOpE),
    .rd     (RdE),
    .busy   (busy),
    .done   (LongDone),
    .long_rd(LongRd)
  );

  logic [REG_AW-1:0] rs_e [2];
  logic [REG_AW-1:0] rs_d [2];
  logic [1:0]        fwd_sel [2];
  logic [1:0]        raw_hit;
  logic [1:0]        lu_hit;
  logic [1:0]        sb_hit;

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;
  assign rs_d[0] = Rs1D;
  assign rs_d[1] = Rs2D;

  // Register 0 is hard-wired, so a zero source index is excluded from every match.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic e_valid, d_valid;
    logic hit_m, hit_long, hit_w;

    assign e_valid  = (rs_e[gi] != '0);
    assign hit_m    = e_valid && RegWriteM && (rs_e[gi] == RdM);
    assign hit_long = e_valid && LongDone && (rs_e[gi] == LongRd);
    assign hit_w    = e_valid && RegWriteW && (rs_e[gi] == RdW);

    assign fwd_sel[gi] = (FWD_EN == 0) ? FWD_RF   :
                         hit_m         ? FWD_M    :
                         hit_long      ? FWD_LONG :
                         hit_w         ? FWD_W    : FWD_RF;

    assign d_valid     = (rs_d[gi] != '0);
    assign raw_hit[gi] = d_valid && ((RegWriteE && (rs_d[gi] == RdE)) ||
                                     (RegWriteM && (rs_d[gi] == RdM)) ||
                                     (RegWriteW && (rs_d[gi] == RdW)));
    assign lu_hit[gi]  = d_valid && (rs_d[gi] == RdE);
    assign sb_hit[gi]  = d_valid && (rs_d[gi] == LongRd);
  end

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

  stall_cause_t cause;
  logic         stall;
  logic         long_pending;

  // The long write port is write-through, so the LongDone cycle itself never stalls.
  assign long_pending     = busy && !LongDone;
  assign cause.raw        = (FWD_EN == 0) && (|raw_hit);
  assign cause.load_use   = ResultSrcE[RESULT_SRC_LOAD_BIT] && (RdE != '0) && (|lu_hit);
  assign cause.scoreboard = long_pending && (|sb_hit);
  assign cause.waw        = long_pending && RegWriteD && (RdD == LongRd);
  assign cause.structural = long_pending && LongOpD;
  assign stall            = |cause;

  assign StallF = stall && !PCSrcE;
  assign StallD = stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = stall || PCSrcE;

  logic unused_result_src;
  assign unused_result_src = ^ResultSrcE;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallD && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (PCSrcE && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign StallCycles = stall_cnt_reg;
  assign FlushCount  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Vector/scoreboard bench for hazard_scoreboard: one forwarding instance and
// one FWD_EN=0 instance driven by the same stimulus.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteD, LongOpD, RegWriteE, LongOpE, RegWriteM, RegWriteW, PCSrcE;
  logic [1:0] ResultSrcE;

  logic [1:0]  ForwardAE, ForwardBE, n_ForwardAE, n_ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, LongDone;
  logic        n_StallF, n_StallD, n_FlushD, n_FlushE, n_LongDone;
  logic [4:0]  LongRd, n_LongRd;
  logic [31:0] StallCycles, FlushCount, n_StallCycles, n_FlushCount;

  hazard_scoreboard #(.REG_AW(5), .LONG_LAT(4), .CNT_W(32), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .LongOpE(LongOpE),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .LongDone(LongDone), .LongRd(LongRd),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  hazard_scoreboard #(.REG_AW(5), .LONG_LAT(4), .CNT_W(32), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .LongOpE(LongOpE),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .ForwardAE(n_ForwardAE), .ForwardBE(n_ForwardBE), .StallF(n_StallF), .StallD(n_StallD),
    .FlushD(n_FlushD), .FlushE(n_FlushE), .LongDone(n_LongDone), .LongRd(n_LongRd),
    .StallCycles(n_StallCycles), .FlushCount(n_FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs plus expected outputs; st/nst are the raw stall conditions of the
  // forwarding and non-forwarding instances before the PCSrcE override.
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rdd;
    logic       wd, lod;
    logic [4:0] rs1e, rs2e, rde;
    logic       we, loe;
    logic [1:0] rse;
    logic [4:0] rdm, rdw;
    logic       wm, ww, pc;
    logic [1:0] fa, fb;
    logic       st, nst, ld;
    logic [4:0] lrd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t v;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur_idx = 0;
  logic [31:0] exp_sc, exp_fc, exp_nsc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h expected %0h", cur_idx, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t d);
    reset = d.rst; Rs1D = d.rs1d; Rs2D = d.rs2d; RdD = d.rdd;
    RegWriteD = d.wd; LongOpD = d.lod;
    Rs1E = d.rs1e; Rs2E = d.rs2e; RdE = d.rde; RegWriteE = d.we; LongOpE = d.loe;
    ResultSrcE = d.rse; RdM = d.rdm; RdW = d.rdw;
    RegWriteM = d.wm; RegWriteW = d.ww; PCSrcE = d.pc;
  endtask

  task automatic compare(input vec_t e);
    logic sd, fe, nsd, nfe;
    sd  = e.st & ~e.pc;
    fe  = e.st | e.pc;
    nsd = e.nst & ~e.pc;
    nfe = e.nst | e.pc;
    chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
    chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
    chk("StallF", 32'(StallF), 32'(sd));
    chk("StallD", 32'(StallD), 32'(sd));
    chk("FlushD", 32'(FlushD), 32'(e.pc));
    chk("FlushE", 32'(FlushE), 32'(fe));
    chk("LongDone", 32'(LongDone), 32'(e.ld));
    chk("LongRd", 32'(LongRd), 32'(e.lrd));
    chk("StallCycles", StallCycles, exp_sc);
    chk("FlushCount", FlushCount, exp_fc);
    chk("nofwd ForwardAE", 32'(n_ForwardAE), 32'(2'b00));
    chk("nofwd ForwardBE", 32'(n_ForwardBE), 32'(2'b00));
    chk("nofwd StallD", 32'(n_StallD), 32'(nsd));
    chk("nofwd FlushE", 32'(n_FlushE), 32'(nfe));
    chk("nofwd LongDone", 32'(n_LongDone), 32'(e.ld));
    chk("nofwd StallCycles", n_StallCycles, exp_nsc);
    if (e.rst) begin
      exp_sc = 0; exp_fc = 0; exp_nsc = 0;
    end else begin
      exp_sc  = exp_sc + 32'(sd);
      exp_fc  = exp_fc + 32'(e.pc);
      exp_nsc = exp_nsc + 32'(nsd);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later,
  // well before the next rising edge.
  task automatic run_queue();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      #2;
      cur_idx = cur_idx + 1;
      compare(sb.pop_front());
    end
    tbl.delete();
  endtask

  initial begin
    v = '0; v.rst = 1'b1;
    drive(v);
    exp_sc = 0; exp_fc = 0; exp_nsc = 0;
    repeat (2) @(posedge clk);

    // Stateless vectors with no long op in flight.
    v = '0; tbl.push_back(v);
    v = '0; v.rdm = 5; v.wm = 1; v.rdw = 5; v.ww = 1; v.rs1e = 5; v.fa = 2'b10; tbl.push_back(v);
    v = '0; v.rdm = 0; v.wm = 1; v.rdw = 5; v.ww = 1; v.rs1e = 5; v.fa = 2'b01; tbl.push_back(v);
    v = '0; v.rdm = 5; v.wm = 0; v.rdw = 5; v.ww = 1; v.rs1e = 5; v.fa = 2'b01; tbl.push_back(v);
    v = '0; v.rs2e = 6; v.rdm = 6; v.wm = 1; v.fb = 2'b10; tbl.push_back(v);
    v = '0; v.rs1e = 3; v.rs2e = 3; v.rdw = 3; v.ww = 1; v.rdm = 4; v.wm = 1; v.fa = 2'b01; v.fb = 2'b01; tbl.push_back(v);
    v = '0; v.rdm = 0; v.wm = 1; v.rdw = 0; v.ww = 1; tbl.push_back(v);
    v = '0; v.rse = 2'b01; v.rde = 7; v.rs2d = 7; v.st = 1; v.nst = 1; tbl.push_back(v);
    v = '0; v.rse = 2'b01; v.rde = 0; tbl.push_back(v);
    v = '0; v.rse = 2'b10; v.rde = 7; v.we = 1; v.rs1d = 7; v.nst = 1; tbl.push_back(v);
    v = '0; v.rs1d = 8; v.rdm = 8; v.wm = 1; v.nst = 1; tbl.push_back(v);
    v = '0; v.rs2d = 9; v.rdw = 9; v.ww = 1; v.nst = 1; tbl.push_back(v);
    v = '0; v.rs1d = 8; v.rdm = 8; v.wm = 0; tbl.push_back(v);
    v = '0; v.rse = 2'b01; v.rde = 7; v.rs1d = 7; v.pc = 1; v.st = 1; v.nst = 1; tbl.push_back(v);
    v = '0; v.pc = 1; tbl.push_back(v);
    v = '0; v.lod = 1; v.wd = 1; v.rdd = 3; tbl.push_back(v);
    v = '0; v.rse = 2'b01; v.rde = 7; v.rs1d = 7; v.st = 1; v.nst = 1; tbl.push_back(v);
    run_queue();

    // Long op to x9: scoreboard stall for three cycles, write-through on LongDone.
    v = '0; v.loe = 1; v.rde = 9; tbl.push_back(v);
    for (int c = 1; c <= 3; c++) begin
      v = '0; v.rs1d = 9; v.st = 1; v.nst = 1; v.lrd = 9; tbl.push_back(v);
    end
    v = '0; v.rs1d = 9; v.rs1e = 9; v.rs2e = 9; v.rdw = 9; v.ww = 1;
    v.fa = 2'b11; v.fb = 2'b11; v.nst = 1; v.ld = 1; v.lrd = 9; tbl.push_back(v);
    v = '0; v.rs1d = 9; v.lrd = 9; tbl.push_back(v);
    run_queue();

    // Structural stall, ignored re-issue while busy, back-to-back long ops, RdE=0 issue.
    v = '0; v.loe = 1; v.rde = 10; v.lrd = 9; tbl.push_back(v);
    v = '0; v.lod = 1; v.st = 1; v.nst = 1; v.lrd = 10; tbl.push_back(v);
    v = '0; v.lod = 1; v.loe = 1; v.rde = 12; v.st = 1; v.nst = 1; v.lrd = 10; tbl.push_back(v);
    v = '0; v.lod = 1; v.st = 1; v.nst = 1; v.lrd = 10; tbl.push_back(v);
    v = '0; v.lod = 1; v.ld = 1; v.lrd = 10; tbl.push_back(v);
    v = '0; v.loe = 1; v.rde = 11; v.lrd = 10; tbl.push_back(v);
    v = '0; v.rs2d = 11; v.st = 1; v.nst = 1; v.lrd = 11; tbl.push_back(v);
    v = '0; v.rs2d = 11; v.wd = 1; v.rdd = 11; v.st = 1; v.nst = 1; v.lrd = 11; tbl.push_back(v);
    v = '0; v.rs2d = 11; v.st = 1; v.nst = 1; v.lrd = 11; tbl.push_back(v);
    v = '0; v.rs2d = 11; v.ld = 1; v.lrd = 11; tbl.push_back(v);
    v = '0; v.loe = 1; v.rde = 0; v.lrd = 11; tbl.push_back(v);
    for (int c = 0; c < 5; c++) begin
      v = '0; v.lod = 1; v.lrd = 11; tbl.push_back(v);
    end
    run_queue();

    // WAW stall, then reset in cycle 2 of a long op discards it.
    v = '0; v.loe = 1; v.rde = 9; v.lrd = 11; tbl.push_back(v);
    v = '0; v.wd = 1; v.rdd = 9; v.st = 1; v.nst = 1; v.lrd = 9; tbl.push_back(v);
    v = '0; v.rst = 1; v.rs1d = 9; v.st = 1; v.nst = 1; v.lrd = 9; tbl.push_back(v);
    for (int c = 0; c < 5; c++) begin
      v = '0; v.rs1d = 9; tbl.push_back(v);
    end
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter LONG_LAT, default 4, long-op latency in cycles from E issue to LongDone; legal range 2..15.
REQ-003 Parameter CNT_W, default 32, performance-counter width.
REQ-004 Parameter FWD_EN, default 1, 1 = forwarding active; 0 = forwarding disabled, RAW resolved by stalling.
REQ-005 Ports, in this order:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  Rs1D, Rs2D, RdD  in  REG_AW  decode-stage source and destination indices
  RegWriteD, LongOpD  in  1  decode instruction writes a register / is a long op
  Rs1E, Rs2E, RdE  in  REG_AW  execute-stage indices
  RegWriteE, LongOpE  in  1  execute instruction writes / is a long op
  ResultSrcE  in  2  bit 0 set = load
  RdM, RdW  in  REG_AW; RegWriteM, RegWriteW  in  1
  PCSrcE  in  1  taken branch or jump
  ForwardAE, ForwardBE  out  2  00 reg file, 01 W, 10 M, 11 long result
  StallF, StallD, FlushD, FlushE  out  1
  LongDone  out  1  long-result writeback pulse
  LongRd  out  REG_AW  long-result destination
  StallCycles, FlushCount  out  CNT_W  performance counters

Function
REQ-006 A source index of 0 never matches and never forwards or stalls.
REQ-007 ForwardAE priority, FWD_EN=1: Rs1E==RdM & RegWriteM -> 10; else Rs1E==LongRd & LongDone -> 11; else Rs1E==RdW & RegWriteW -> 01; else 00. ForwardBE uses Rs2E with the same rules and drives only ForwardBE.
REQ-008 With FWD_EN=0, ForwardAE/BE are constant 00; D stalls while Rs1D/Rs2D match RdE, RdM or RdW of a writing stage.
REQ-009 Load-use stall: ResultSrcE[0] & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
REQ-010 Scoreboard stall: Busy & (Rs1D==LongRd | Rs2D==LongRd) & !LongDone. The long write port is write-through to D reads.
REQ-011 WAW stall: Busy & RegWriteD & RdD==LongRd & !LongDone.
REQ-012 Structural stall: LongOpD & Busy & !LongDone.
REQ-013 Stall = OR of REQ-008..012; StallF = StallD = Stall & !PCSrcE.
REQ-014 FlushD = PCSrcE; FlushE = Stall | PCSrcE.
REQ-015 Issue: LongOpE & !Busy & RdE!=0 sets Busy, latches LongRd = RdE, and loads Cnt = LONG_LAT-1.
REQ-016 Busy & Cnt!=0: Cnt decrements by 1 each cycle.
REQ-017 Busy & Cnt==0: LongDone=1 for exactly one cycle; Busy clears at the next edge.
REQ-018 LongOpE while Busy & !LongDone is a protocol violation; it is ignored and state is unchanged.
REQ-019 LongOpE with RdE==0 does not set Busy and never produces LongDone.
REQ-020 Issue in the same cycle as LongDone is impossible by REQ-012; no special handling is required.
REQ-021 StallCycles increments in each cycle StallD=1 and saturates at all-ones.
REQ-022 FlushCount increments in each cycle PCSrcE=1 and saturates at all-ones.
REQ-023 Forward and stall outputs are combinational from inputs and the registered state; they have zero latency.

Reset
REQ-024 When reset is high at a rising edge: Busy=0, Cnt=0, LongRd=0, StallCycles=0, FlushCount=0.
REQ-025 Reset mid long-op discards that op: no LongDone follows.
REQ-026 While Busy=0, LongDone=0 and no scoreboard, WAW or structural stall asserts.

Structure
REQ-027 A shared package holds the forward-select constants (FWD_RF, FWD_W, FWD_M, FWD_LONG) and the load bit position of ResultSrc.
REQ-028 The long-op tracker (Busy, Cnt, LongRd, LongDone) is one sub-module, long_op_tracker, parametrised by REG_AW and LONG_LAT.

Verification
REQ-029 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with Rs2E=0 and RdM=0 -> ForwardBE=00.
REQ-030 ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle; StallCycles increments by 1.
REQ-031 LONG_LAT=4, LongOpE with RdE=9 at cycle 0 -> LongDone=1, LongRd=9 in cycle 4 only; Rs1D=9 stalls cycles 1-3 and releases in cycle 4.
REQ-032 Long op pending, LongOpD=1 -> stall until the LongDone cycle; the second op issues the next cycle.
REQ-033 PCSrcE=1 concurrent with a load-use hazard -> FlushD=FlushE=1 and StallF=StallD=0.
REQ-034 Reset asserted in cycle 2 of a long op -> Busy=0 and no LongDone; counters read 0.
